// File: rtl/n64_vinfo_ext_v2.sv
// Video-info extractor for the demuxed N64 bus: data slot counter, 240p/480i, PAL/NTSC with
// field hysteresis, signal-lost watchdog and valid flag. Define N64_VINFO_LINECNT_EN to export lines_per_field_o.
module n64_vinfo_ext_v2 #(
    parameter int color_width_i = 7,
    parameter int LINE_CNT_W    = 10,
    parameter int PAL_THRESH    = 288,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT_W     = 19
) (
    input  logic                     nCLK,
    input  logic                     nRST,
    input  logic                     nDSYNC,
    input  logic [3:0]               Sync_pre,
    input  logic [color_width_i-1:0] D_i,
    output logic [4:0]               vinfo_o,
    output logic                     vinfo_valid_o
`ifdef N64_VINFO_LINECNT_EN
    ,
    output logic [LINE_CNT_W-1:0]    lines_per_field_o
`endif
);

    localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;
    localparam logic [TIMEOUT_W-1:0]  WD_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0]  WD_TRIP  = WD_MAX - TIMEOUT_W'(1);
    localparam logic [4:0]            STABLE   = 5'(STABLE_FRAMES);

    logic [1:0]            data_cnt_q, data_cnt_d;
    logic                  n64_480i_q, n64_480i_d;
    logic                  vmode_q, vmode_d;
    logic                  blurry_q, blurry_d;
    logic                  valid_q, valid_d;
    logic                  armed_q, armed_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_CNT_W-1:0] field_len_q, field_len_d;
    logic [3:0]            stab_v_q, stab_v_d;
    logic [3:0]            stab_i_q, stab_i_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;

    logic vs_neg, vs_pos, hs_neg, hs_pos, cs_pos, line_sat, cand;
    logic [4:0] stab_v_inc, stab_i_inc;

    assign vs_neg     = Sync_pre[3] & ~D_i[3];
    assign vs_pos     = ~Sync_pre[3] & D_i[3];
    assign hs_neg     = Sync_pre[1] & ~D_i[1];
    assign hs_pos     = ~Sync_pre[1] & D_i[1];
    assign cs_pos     = ~Sync_pre[0] & D_i[0];
    assign line_sat   = (line_cnt_q == LINE_MAX);
    assign cand       = (line_cnt_q > LINE_CNT_W'(PAL_THRESH));
    assign stab_v_inc = {1'b0, stab_v_q} + 5'd1;
    assign stab_i_inc = {1'b0, stab_i_q} + 5'd1;

    always_comb begin
        data_cnt_d  = nDSYNC ? data_cnt_q + 2'd1 : 2'd1;
        n64_480i_d  = n64_480i_q;
        vmode_d     = vmode_q;
        blurry_d    = blurry_q;
        valid_d     = valid_q;
        armed_d     = armed_q;
        line_cnt_d  = line_cnt_q;
        field_len_d = field_len_q;
        stab_v_d    = stab_v_q;
        stab_i_d    = stab_i_q;
        wd_d        = wd_q;
        if (!nDSYNC) begin
            // First vs_pos after reset/timeout only arms: the field before it was partial.
            if (vs_pos) begin
                field_len_d = line_cnt_q;
                line_cnt_d  = '0;
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (line_sat) begin
                    valid_d  = 1'b0;
                    stab_v_d = '0;
                end else begin
                    valid_d = 1'b1;
                    if (cand == vmode_q) begin
                        stab_v_d = '0;
                    end else if (stab_v_inc >= STABLE) begin
                        vmode_d  = cand;
                        stab_v_d = '0;
                    end else begin
                        stab_v_d = stab_v_inc[3:0];
                    end
                end
            end else if (hs_pos && !line_sat) begin
                line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
            end

            if (vs_neg) begin
                wd_d = '0;
                if (!hs_neg) begin
                    n64_480i_d = 1'b1;
                    stab_i_d   = '0;
                end else begin
                    if (stab_i_q != 4'hF) stab_i_d = stab_i_inc[3:0];
                    if (stab_i_inc >= STABLE) n64_480i_d = 1'b0;
                end
            end else begin
                if (wd_q != WD_MAX) wd_d = wd_q + TIMEOUT_W'(1);
                // Signal lost: drop lock but keep the last vmode and field length.
                if (wd_q >= WD_TRIP) begin
                    valid_d    = 1'b0;
                    armed_d    = 1'b0;
                    n64_480i_d = 1'b1;
                    stab_i_d   = '0;
                    stab_v_d   = '0;
                end
            end

            if (n64_480i_d)  blurry_d = 1'b1;
            else if (cs_pos) blurry_d = ~vmode_q;
            else             blurry_d = ~blurry_q;
        end
    end

    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            data_cnt_q  <= 2'b00;
            n64_480i_q  <= 1'b1;
            vmode_q     <= 1'b0;
            blurry_q    <= 1'b1;
            valid_q     <= 1'b0;
            armed_q     <= 1'b0;
            line_cnt_q  <= '0;
            field_len_q <= '0;
            stab_v_q    <= '0;
            stab_i_q    <= '0;
            wd_q        <= '0;
        end else begin
            data_cnt_q  <= data_cnt_d;
            n64_480i_q  <= n64_480i_d;
            vmode_q     <= vmode_d;
            blurry_q    <= blurry_d;
            valid_q     <= valid_d;
            armed_q     <= armed_d;
            line_cnt_q  <= line_cnt_d;
            field_len_q <= field_len_d;
            stab_v_q    <= stab_v_d;
            stab_i_q    <= stab_i_d;
            wd_q        <= wd_d;
        end
    end

    assign vinfo_o       = {data_cnt_q, n64_480i_q, vmode_q, blurry_q};
    assign vinfo_valid_o = valid_q;

    logic unused_bits;
`ifdef N64_VINFO_LINECNT_EN
    assign lines_per_field_o = field_len_q;
    assign unused_bits = ^{D_i[color_width_i-1:4], D_i[2], Sync_pre[2]};
`else
    assign unused_bits = ^{D_i[color_width_i-1:4], D_i[2], Sync_pre[2], field_len_q};
`endif

endmodule
